// File: rtl/trafficlight_pkg.sv
// Shared types and timing helpers for the traffic-light controller and its front ends.
package trafficlight_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PDEB,
        S_HELD,
        S_RDEB
    } btn_state_t;

    function automatic int ms_to_cycles(input int freq, input int ms);
        return freq / 1000 * ms;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous board inputs; reset value is a parameter
// so an idle-high input can come out of reset already in its released state.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic nreset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ped_button_conditioner.sv
// Pedestrian button front end: synchronise, debounce, press/long-press pulses and a held
// request level that the traffic-light controller clears once the crossing has been served.
module ped_button_conditioner
    import trafficlight_pkg::*;
#(
    parameter int FPGAFREQ     = 50_000_000,
    parameter int DEBOUNCE_MS  = 20,
    parameter int LONGPRESS_MS = 2000
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       b_npeaton,
    input  logic       accept_en,
    input  logic       req_ack,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       long_pulse,
    output logic       sol_req,
    output logic       sol_light,
    output btn_state_t state_dbg
);

    localparam int DEB_CYC  = ms_to_cycles(FPGAFREQ, DEBOUNCE_MS);
    localparam int LONG_CYC = ms_to_cycles(FPGAFREQ, LONGPRESS_MS);
    localparam int CW       = $clog2(LONG_CYC + 1);

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYC - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - DEB_CYC - 1);
    localparam logic [CW-1:0] LONG_MAX  = CW'(LONG_CYC);

    logic          btn_sync;
    logic          btn_s;
    btn_state_t    state, state_nx;
    logic [CW-1:0] deb_cnt, deb_cnt_nx;
    logic [CW-1:0] long_cnt, long_cnt_nx;
    logic          press_nx, long_nx, level_nx, req_nx;

    // Released button reads high, so the synchroniser resets to 1.
    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk    (clk),
        .nreset (nreset),
        .d      (b_npeaton),
        .q      (btn_sync)
    );

    assign btn_s = ~btn_sync;

    always_comb begin
        state_nx    = state;
        deb_cnt_nx  = deb_cnt;
        long_cnt_nx = long_cnt;
        press_nx    = 1'b0;
        long_nx     = 1'b0;
        case (state)
            S_IDLE: begin
                long_cnt_nx = '0;
                if (btn_s) begin
                    state_nx   = S_PDEB;
                    deb_cnt_nx = '0;
                end
            end
            S_PDEB: begin
                if (!btn_s) begin
                    state_nx = S_IDLE;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nx    = S_HELD;
                    press_nx    = 1'b1;
                    deb_cnt_nx  = '0;
                    long_cnt_nx = '0;
                end else begin
                    deb_cnt_nx = deb_cnt + 1'b1;
                end
            end
            S_HELD: begin
                if (!btn_s) begin
                    state_nx   = S_RDEB;
                    deb_cnt_nx = '0;
                end else begin
                    // Saturating so the long-press match can only ever be hit once per press.
                    if (long_cnt != LONG_MAX) long_cnt_nx = long_cnt + 1'b1;
                    if (long_cnt == LONG_LAST) long_nx = 1'b1;
                end
            end
            S_RDEB: begin
                if (btn_s) begin
                    state_nx = S_HELD;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nx = S_IDLE;
                end else begin
                    deb_cnt_nx = deb_cnt + 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        level_nx = (state_nx == S_HELD) || (state_nx == S_RDEB);
    end

    // Request handshake: sol_req is raised by an accepted press and stays high until the
    // controller pulses req_ack for one cycle; ack wins over a same-cycle press, and a long
    // press withdraws the request.
    always_comb begin
        req_nx = sol_req;
        if (req_ack)                        req_nx = 1'b0;
        else if (long_pulse)                req_nx = 1'b0;
        else if (press_pulse && accept_en)  req_nx = 1'b1;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state       <= S_IDLE;
            deb_cnt     <= '0;
            long_cnt    <= '0;
            btn_level   <= 1'b0;
            press_pulse <= 1'b0;
            long_pulse  <= 1'b0;
            sol_req     <= 1'b0;
        end else begin
            state       <= state_nx;
            deb_cnt     <= deb_cnt_nx;
            long_cnt    <= long_cnt_nx;
            btn_level   <= level_nx;
            press_pulse <= press_nx;
            long_pulse  <= long_nx;
            sol_req     <= req_nx;
        end
    end

    assign sol_light = sol_req;
    assign state_dbg = state;

endmodule

// File: tb/tb_ped_button_conditioner.sv
// Bench for ped_button_conditioner with a sample-history reference model of debounce and request rules.
module tb_ped_button_conditioner;
    import trafficlight_pkg::*;

    localparam int FPGAFREQ     = 8000;
    localparam int DEBOUNCE_MS  = 2;
    localparam int LONGPRESS_MS = 10;
    localparam int DEB_CYC      = FPGAFREQ / 1000 * DEBOUNCE_MS;
    localparam int LONG_CYC     = FPGAFREQ / 1000 * LONGPRESS_MS;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       b_npeaton = 1'b1;
    logic       accept_en = 1'b0;
    logic       req_ack = 1'b0;
    logic       btn_level, press_pulse, long_pulse, sol_req, sol_light;
    btn_state_t state_dbg;

    ped_button_conditioner #(
        .FPGAFREQ     (FPGAFREQ),
        .DEBOUNCE_MS  (DEBOUNCE_MS),
        .LONGPRESS_MS (LONGPRESS_MS)
    ) dut (
        .clk         (clk),
        .nreset      (nreset),
        .b_npeaton   (b_npeaton),
        .accept_en   (accept_en),
        .req_ack     (req_ack),
        .btn_level   (btn_level),
        .press_pulse (press_pulse),
        .long_pulse  (long_pulse),
        .sol_req     (sol_req),
        .sol_light   (sol_light),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [4:0] exp_q[$];   // {btn_level, press, long, sol_req, sol_light}

    // reference model: raw samples, run lengths of the synchronised level, hold time
    logic raw_q[$];
    int   ones_run, zeros_run, hold_cnt;
    bit   prev_s;
    bit   m_level, m_press, m_long, m_req;

    // per-phase observations of the DUT
    int edge_no, press_at, long_at, n_press_seen, n_long_seen, level_drops;
    bit ack_on_press = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_clear();
        raw_q = {1'b1, 1'b1};
        ones_run = 0; zeros_run = 0; hold_cnt = 0; prev_s = 1'b0;
        m_level = 1'b0; m_press = 1'b0; m_long = 1'b0; m_req = 1'b0;
    endfunction

    // One clock edge: the controller-facing request first (from last cycle's pulses), then the
    // button: a level change needs DEB_CYC+1 consecutive agreeing samples; hold time counts
    // pressed samples that directly follow another pressed sample while the level is pressed.
    function automatic void model_step();
        bit s;
        s = !raw_q[raw_q.size() - 2];
        raw_q.push_back(b_npeaton);
        void'(raw_q.pop_front());
        if (req_ack)                   m_req = 1'b0;
        else if (m_long)               m_req = 1'b0;
        else if (m_press && accept_en) m_req = 1'b1;
        m_press = 1'b0;
        m_long  = 1'b0;
        if (s) begin ones_run++; zeros_run = 0; end
        else   begin zeros_run++; ones_run = 0; end
        if (!m_level) begin
            if (ones_run == DEB_CYC + 1) begin
                m_level = 1'b1; m_press = 1'b1; hold_cnt = 0;
            end
        end else if (zeros_run == DEB_CYC + 1) begin
            m_level = 1'b0;
        end else if (s && prev_s) begin
            if (hold_cnt < LONG_CYC) hold_cnt++;
            if (hold_cnt == LONG_CYC - DEB_CYC) m_long = 1'b1;
        end
        prev_s = s;
        exp_q.push_back({m_level, m_press, m_long, m_req, m_req});
    endfunction

    // ---------------- driver ----------------
    task automatic clear_stats();
        edge_no = 0; press_at = 999; long_at = 999;
        n_press_seen = 0; n_long_seen = 0; level_drops = 0;
    endtask

    task automatic tick();
        logic [4:0] e;
        @(posedge clk);
        if (nreset) model_step();
        else exp_q.push_back('0);
        #1;
        e = exp_q.pop_front();
        check("btn_level",   btn_level,   e[4]);
        check("press_pulse", press_pulse, e[3]);
        check("long_pulse",  long_pulse,  e[2]);
        check("sol_req",     sol_req,     e[1]);
        check("sol_light",   sol_light,   e[0]);
        edge_no++;
        if (press_pulse) begin n_press_seen++; if (press_at == 999) press_at = edge_no; end
        if (long_pulse)  begin n_long_seen++;  if (long_at == 999)  long_at  = edge_no; end
        if (!btn_level) level_drops++;
        if (ack_on_press) req_ack = m_press;
    endtask

    task automatic hold(input logic val, input int n);
        b_npeaton = val;
        repeat (n) tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_clear();
        clear_stats();
        #2;
        check("rst_level", btn_level, 0);
        check("rst_press", press_pulse, 0);
        check("rst_req",   sol_req, 0);
        check("rst_state", state_dbg, S_IDLE);
        repeat (2) tick();
        nreset = 1'b1;
        hold(1'b1, 5);

        // clean press then acknowledge
        accept_en = 1'b1;
        clear_stats();
        hold(1'b0, 40);
        check("press_latency", press_at, DEB_CYC + 3);
        check("press_count", n_press_seen, 1);
        check("no_long_short_hold", n_long_seen, 0);
        hold(1'b1, 30);
        check("req_held", sol_req, 1);
        req_ack = 1'b1; tick(); req_ack = 1'b0;
        check("ack_clear", sol_req, 0);
        req_ack = 1'b1; tick(); req_ack = 1'b0;
        check("ack_idle", sol_req, 0);

        // press bounce never settles long enough
        clear_stats();
        for (int i = 0; i < 12; i++) hold(i[0], 5);
        hold(1'b1, 30);
        check("bounce_no_press", n_press_seen, 0);
        check("bounce_no_req", sol_req, 0);

        // release bounce while held
        hold(1'b0, 30);
        clear_stats();
        for (int i = 0; i < 8; i++) hold(~i[0], 5);
        check("rel_bounce_level", level_drops, 0);
        check("rel_bounce_no_press", n_press_seen, 0);
        hold(1'b1, 30);
        check("rel_done_level", btn_level, 0);

        // long press cancels a pending request
        check("pre_long_req", sol_req, 1);
        clear_stats();
        hold(1'b0, 100);
        check("long_latency", long_at, LONG_CYC + 3);
        check("long_once", n_long_seen, 1);
        check("long_cancel", sol_req, 0);
        hold(1'b1, 30);

        // press while not accepting is dropped
        accept_en = 1'b0;
        clear_stats();
        hold(1'b0, 30);
        hold(1'b1, 30);
        check("gated_press_seen", n_press_seen, 1);
        check("gated_no_req", sol_req, 0);

        // ack coincident with press pulse wins
        accept_en = 1'b1;
        ack_on_press = 1'b1;
        hold(1'b0, 30);
        ack_on_press = 1'b0;
        req_ack = 1'b0;
        check("ack_beats_press", sol_req, 0);
        hold(1'b1, 30);

        // async reset while held with a pending request
        hold(1'b0, 30);
        check("pre_rst_req", sol_req, 1);
        nreset = 1'b0;
        #1;
        model_clear();
        check("async_level", btn_level, 0);
        check("async_req",   sol_req, 0);
        check("async_light", sol_light, 0);
        check("async_state", state_dbg, S_IDLE);
        repeat (3) tick();
        nreset = 1'b1;
        clear_stats();
        repeat (30) tick();
        check("post_rst_latency", press_at, DEB_CYC + 3);
        check("post_rst_req", sol_req, 1);
        hold(1'b1, 30);

        // randomized segments: levels, short bounces, long holds, gating and acks
        for (int seg = 0; seg < 60; seg++) begin
            int len;
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(10, 120);
            b_npeaton = ~b_npeaton;
            if ($urandom_range(0, 4) == 0) accept_en = ~accept_en;
            for (int c = 0; c < len; c++) begin
                req_ack = ($urandom_range(0, 15) == 0);
                tick();
            end
            req_ack = 1'b0;
        end
        hold(1'b1, 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
